// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction fetch stage with a valid/ready IR handoff to decode.
// Optional FETCH_PERF_EN builds handshake/stall counters; otherwise perf outputs are tied to zero.

`ifndef TEXT_BASE_ADDRESS
`define TEXT_BASE_ADDRESS 32'h0000_3000
`endif

module fetch_unit #(
    parameter int MEM_LATENCY = 0,
    parameter int INDEX_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_stalls
);

    localparam logic [31:0] TEXT_BASE = `TEXT_BASE_ADDRESS;
    localparam logic [1:0]  LAT       = 2'(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] ir_pc_q;
    logic        ir_valid_q;
    logic        fault_q;
    logic [1:0]  cnt_q;

    logic [31:0] win_off;
    logic        pc_bad;

    // Unsigned offset: addresses below the base wrap high and fail the window test too.
    assign win_off = pc_q - TEXT_BASE;
    assign pc_bad  = (pc_q[1:0] != 2'b00) || ((win_off >> (INDEX_W + 2)) != 32'd0);

    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign pc_plus4  = ir_pc_q + 32'd4;
    assign fault     = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= TEXT_BASE;
            ir_q       <= 32'd0;
            ir_pc_q    <= TEXT_BASE;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= 2'd0;
        end else if (redirect) begin
            // Redirect wins over capture and over a handshake in HOLD; the IR is dropped.
            state_q    <= S_REQ;
            pc_q       <= redirect_pc;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (pc_bad) begin
                        state_q    <= S_FAULT;
                        fault_q    <= 1'b1;
                        ir_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if (cnt_q != LAT) begin
                            cnt_q <= cnt_q + 2'd1;
                        end else begin
                            ir_q       <= imem_dout;
                            ir_pc_q    <= pc_q;
                            pc_q       <= pc_q + 32'd4;
                            ir_valid_q <= 1'b1;
                            cnt_q      <= 2'd0;
                            state_q    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (ir_valid_q && ir_ready) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= S_REQ;
                    end
                end
                S_FAULT: begin
                    fault_q    <= 1'b1;
                    ir_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_REQ;
                    ir_valid_q <= 1'b0;
                    cnt_q      <= 2'd0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetches_q <= 32'd0;
            perf_stalls_q  <= 32'd0;
        end else begin
            if (ir_valid_q && ir_ready && !redirect)
                perf_fetches_q <= perf_fetches_q + 32'd1;
            if ((state_q == S_REQ) && stall)
                perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_fetches = perf_fetches_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_fetches = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit at read latency 0 and 2.

module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == BASE) return 32'h2008_0005;
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    logic        rst0, ready0, stall0, redirect0;
    logic [31:0] rpc0;
    logic [31:0] addr0, dout0, ir0, irpc0, pcp40, pf0, ps0;
    logic        valid0, fault0;

    logic        rst2, ready2, stall2, redirect2;
    logic [31:0] rpc2;
    logic [31:0] addr2, dout2, ir2, irpc2, pcp42, pf2, ps2;
    logic        valid2, fault2;

    assign dout0 = mem_word(addr0);
    assign dout2 = mem_word(addr2);

    fetch_unit #(.MEM_LATENCY(0), .INDEX_W(10)) u0 (
        .clk(clk), .rst(rst0), .imem_addr(addr0), .imem_dout(dout0),
        .ir(ir0), .ir_valid(valid0), .ir_ready(ready0), .ir_pc(irpc0),
        .pc_plus4(pcp40), .stall(stall0), .redirect(redirect0),
        .redirect_pc(rpc0), .fault(fault0),
        .perf_fetches(pf0), .perf_stalls(ps0)
    );

    fetch_unit #(.MEM_LATENCY(2), .INDEX_W(10)) u2 (
        .clk(clk), .rst(rst2), .imem_addr(addr2), .imem_dout(dout2),
        .ir(ir2), .ir_valid(valid2), .ir_ready(ready2), .ir_pc(irpc2),
        .pc_plus4(pcp42), .stall(stall2), .redirect(redirect2),
        .redirect_pc(rpc2), .fault(fault2),
        .perf_fetches(pf2), .perf_stalls(ps2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b0; ready0 = 1'b1; stall0 = 1'b0; redirect0 = 1'b0; rpc0 = 32'd0;
        rst2 = 1'b0; ready2 = 1'b1; stall2 = 1'b1; redirect2 = 1'b0; rpc2 = 32'd0;

        step(); step();
        chk("rst_valid", {31'd0, valid0}, 32'd0);
        chk("rst_ir", ir0, 32'd0);
        chk("rst_irpc", irpc0, BASE);
        chk("rst_addr", addr0, BASE);
        chk("rst_fault", {31'd0, fault0}, 32'd0);
        chk("rst_pcp4", pcp40, BASE + 32'd4);

        // Latency 0: capture on the first edge after release.
        rst0 = 1'b1;
        step();
        chk("l0_valid", {31'd0, valid0}, 32'd1);
        chk("l0_ir", ir0, 32'h2008_0005);
        chk("l0_irpc", irpc0, 32'h0000_3000);
        chk("l0_pcp4", pcp40, 32'h0000_3004);
        chk("l0_next_addr", addr0, 32'h0000_3004);

        // Back-pressure in HOLD.
        ready0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_valid", {31'd0, valid0}, 32'd1);
            chk("hold_ir", ir0, 32'h2008_0005);
            chk("hold_irpc", irpc0, 32'h0000_3000);
            chk("hold_addr", addr0, 32'h0000_3004);
        end
        ready0 = 1'b1;
        step();
        chk("hs_drop", {31'd0, valid0}, 32'd0);
        step();
        chk("f2_valid", {31'd0, valid0}, 32'd1);
        chk("f2_irpc", irpc0, 32'h0000_3004);
        chk("f2_ir", ir0, mem_word(32'h0000_3004));

        // Redirect in HOLD with ready high: not a handshake, IR discarded.
        redirect0 = 1'b1; rpc0 = 32'h0000_3040;
        step();
        chk("rdh_valid", {31'd0, valid0}, 32'd0);
        chk("rdh_addr", addr0, 32'h0000_3040);
        redirect0 = 1'b0;
        step();
        chk("rdh_valid2", {31'd0, valid0}, 32'd1);
        chk("rdh_irpc", irpc0, 32'h0000_3040);
        chk("rdh_ir", ir0, mem_word(32'h0000_3040));

        // Misaligned target faults.
        redirect0 = 1'b1; rpc0 = 32'h0000_3042;
        step();
        chk("mis_fault0", {31'd0, fault0}, 32'd0);
        redirect0 = 1'b0;
        step();
        chk("mis_fault1", {31'd0, fault0}, 32'd1);
        chk("mis_valid", {31'd0, valid0}, 32'd0);
        step();
        chk("mis_fault_stay", {31'd0, fault0}, 32'd1);
        chk("mis_valid_stay", {31'd0, valid0}, 32'd0);

        // First word past the window faults.
        redirect0 = 1'b1; rpc0 = 32'h0000_4000;
        step();
        chk("win_clr", {31'd0, fault0}, 32'd0);
        redirect0 = 1'b0;
        step();
        chk("win_fault", {31'd0, fault0}, 32'd1);
        chk("win_valid", {31'd0, valid0}, 32'd0);

        // Last word inside the window fetches, then pc+4 steps out and faults.
        redirect0 = 1'b1; rpc0 = 32'h0000_3FFC;
        step();
        redirect0 = 1'b0;
        step();
        chk("last_valid", {31'd0, valid0}, 32'd1);
        chk("last_irpc", irpc0, 32'h0000_3FFC);
        chk("last_fault", {31'd0, fault0}, 32'd0);
        step();
        chk("last_addr", addr0, 32'h0000_4000);
        step();
        chk("last_step_fault", {31'd0, fault0}, 32'd1);

        redirect0 = 1'b1; rpc0 = BASE;
        step();
        chk("rec_fault", {31'd0, fault0}, 32'd0);
        redirect0 = 1'b0;
        step();
        chk("rec_valid", {31'd0, valid0}, 32'd1);
        chk("rec_ir", ir0, 32'h2008_0005);

`ifdef FETCH_PERF_EN
        chk("perf_pre_f", pf0, 32'd2);
`else
        chk("perf_tied_f", pf0, 32'd0);
`endif

        // Asynchronous reset mid-cycle clears everything without an edge.
        #2;
        rst0 = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid0}, 32'd0);
        chk("arst_ir", ir0, 32'd0);
        chk("arst_irpc", irpc0, BASE);
        chk("arst_addr", addr0, BASE);
        chk("arst_pf", pf0, 32'd0);
        chk("arst_ps", ps0, 32'd0);
        step();
        rst0 = 1'b1; stall0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_valid", {31'd0, valid0}, 32'd0);
            chk("st_addr", addr0, BASE);
        end
        stall0 = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("perf_run_valid", {31'd0, valid0}, 32'd0);
        chk("perf_run_addr", addr0, 32'h0000_3014);
        chk("perf_run_irpc", irpc0, 32'h0000_3010);
`ifdef FETCH_PERF_EN
        chk("perf_fetches", pf0, 32'd5);
        chk("perf_stalls", ps0, 32'd3);
`else
        chk("perf_tied_f2", pf0, 32'd0);
        chk("perf_tied_s2", ps0, 32'd0);
`endif

        // Latency 2 with three stalled cycles: capture 6 edges after entering REQ.
        rst2 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk("l2_wait_valid", {31'd0, valid2}, 32'd0);
            chk("l2_wait_addr", addr2, BASE);
            if (e == 3) stall2 = 1'b0;
        end
        step();
        chk("l2_cap_valid", {31'd0, valid2}, 32'd1);
        chk("l2_cap_irpc", irpc2, BASE);
        chk("l2_cap_ir", ir2, 32'h2008_0005);
        step();
        chk("l2_hs", {31'd0, valid2}, 32'd0);
        step();
        redirect2 = 1'b1; rpc2 = 32'h0000_3040;
        step();
        chk("l2_rd_valid", {31'd0, valid2}, 32'd0);
        chk("l2_rd_addr", addr2, 32'h0000_3040);
        redirect2 = 1'b0;
        step(); step();
        chk("l2_rd_wait", {31'd0, valid2}, 32'd0);
        step();
        chk("l2_rd_cap", {31'd0, valid2}, 32'd1);
        chk("l2_rd_irpc", irpc2, 32'h0000_3040);
        chk("l2_rd_ir", ir2, mem_word(32'h0000_3040));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage of the multi-cycle CPU, directly upstream of the instruction memory.
- Owns the PC and drives the instruction memory address.
- Waits a configurable read latency, then captures the returned word into the instruction register (IR).
- Hands the IR to decode over a valid/ready handshake; supports control-flow redirects from the execute/branch logic.

Parameters:
- MEM_LATENCY, 0, cycles between imem_addr becoming stable and the capture of imem_dout (legal 0..3).
- INDEX_W, 10, word-index width of instruction memory; fetchable window is 2^INDEX_W words from `TEXT_BASE_ADDRESS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; combinationally equal to pc.
- imem_dout  in  32  instruction word from instruction memory.
- ir  out  32  captured instruction.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- ir_pc  out  32  address the current ir was fetched from.
- pc_plus4  out  32  ir_pc + 4 (link value for jal).
- stall  in  1  freeze the fetch wait counter.
- redirect  in  1  load redirect_pc and discard the in-flight fetch.
- redirect_pc  in  32  new fetch address.
- fault  out  1  pc is misaligned or outside the fetch window.

Behaviour:
- Reset (rst low, asynchronous):
  - pc=`TEXT_BASE_ADDRESS, ir=0, ir_pc=`TEXT_BASE_ADDRESS.
  - ir_valid=0, fault=0, wait counter=0, state=REQ.
  - Outputs hold these values for as long as rst is low.
- States: REQ, HOLD, FAULT.
- REQ:
  - If pc[1:0]!=0 or (pc-`TEXT_BASE_ADDRESS) >= 4*2^INDEX_W: next state FAULT, no capture.
  - Else, if stall=1: counter holds.
  - Else, if counter<MEM_LATENCY: counter+1.
  - Else, at this edge: ir<=imem_dout, ir_pc<=pc, pc<=pc+4, ir_valid<=1, counter<=0, next state HOLD.
  - Latency: ir_valid rises MEM_LATENCY+1 edges after entering REQ, when there are no stalls.
- HOLD:
  - ir, ir_pc and ir_valid are stable.
  - On an edge with ir_valid=1 and ir_ready=1: ir_valid<=0, next state REQ.
  - Otherwise remain in HOLD.
  - stall is ignored in HOLD.
- FAULT:
  - fault=1, ir_valid=0, no memory capture.
  - Left only through redirect or reset.
- Redirect (any state; highest priority after reset):
  - pc<=redirect_pc, ir_valid<=0, counter<=0, fault<=0, next state REQ.
  - An edge with redirect=1 and ir_ready=1 in HOLD is not a completed handshake; the IR is discarded.
  - A capture due on the same edge as a redirect is suppressed.
- Arithmetic:
  - pc+4 wraps modulo 2^32 with no special handling; the wrapped value then faults via the window check.
  - pc_plus4 = ir_pc+4, combinational.
- imem_addr is combinational from pc only, so it stays stable through every REQ cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetches[31:0] and perf_stalls[31:0].
  - perf_fetches increments on each completed handshake (ir_valid & ir_ready & !redirect).
  - perf_stalls increments on each REQ cycle with stall=1.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports still exist but are tied to 0, and no counter registers are built.

Test Plan:
- Reset then release with MEM_LATENCY=0, imem model returning 0x20080005 at 0x00003000 and ir_ready=1 -> ir_valid high 1 edge after release; ir=0x20080005, ir_pc=0x00003000, pc_plus4=0x00003004; the next fetch drives imem_addr=0x00003004.
- MEM_LATENCY=2 with stall held high for 3 cycles in REQ -> capture occurs exactly 6 edges after entering REQ; imem_addr is constant throughout.
- ir_ready=0 for 4 cycles in HOLD -> ir, ir_pc and ir_valid unchanged and imem_addr=ir_pc+4; ir_ready=1 -> ir_valid drops next edge.
- redirect=1 with redirect_pc=0x00003040, issued in REQ mid-wait and again in HOLD with ir_ready=1 -> ir_valid=0, the next fetch is from 0x00003040, and the old IR is never re-presented.
- redirect_pc=0x00003042, then 0x00004000 (INDEX_W=10) -> fault=1 and ir_valid stays 0; a redirect to 0x00003000 clears fault, and a fetch completes.
- With FETCH_PERF_EN: 5 handshakes plus 3 stall cycles -> perf_fetches=5, perf_stalls=3; asserting rst low mid-run zeroes both counters and all outputs immediately, without waiting for a clock edge.
